layered_mac_stage: RTL and testbench

Parametrised first-stage multiply-accumulate engine for the network datapath. Per layer it accumulates a dot product of a selected A-channel element stream against that layer's B element stream. It emits one rectified, fixed-point-scaled result per layer and steps through `N_LAYERS` layers per `go`. It adds two things to the fixed 4-way stage: a pipelined result register that allows back-to-back layers with no bubble, and an explicit `abort`.

---
 rtl/layered_mac_stage.sv | 182 ++++++++++++++++++
 tb/tb_layered_mac_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layered_mac_stage.sv
// Multi-layer dot-product MAC: one rectified, fixed-point-scaled result per layer, N_LAYERS layers per go.
// Define LAYERED_MAC_STAGE_SATURATE_EN to clamp positive overflow of z_element instead of truncating.
`timescale 1ns/1ps
module layered_mac_stage #(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 16,
    parameter int N_LAYERS  = 4,
    parameter int N_SEL     = 4,
    localparam int SEL_W    = $clog2(N_SEL),
    localparam int LAYER_W  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
    input  logic                         clock,
    input  logic                         clear_n,
    input  logic                         go,
    input  logic                         abort,
    input  logic [SEL_W-1:0]             sel,
    input  logic [N_SEL*DATA_W-1:0]      a_elements,
    input  logic                         a_element_ready,
    input  logic [N_LAYERS*DATA_W-1:0]   b_elements,
    input  logic                         b_element_ready,
    input  logic                         last_element,
    output logic [DATA_W-1:0]            z_element,
    output logic                         z_element_ready,
    output logic [LAYER_W-1:0]           z_layer,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [LAYER_W-1:0]      LAST_LAYER = LAYER_W'(N_LAYERS - 1);
    localparam logic signed [ACC_W-1:0] ACC_ZERO   = '0;
`ifdef LAYERED_MAC_STAGE_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_LIMIT  = ACC_W'(1) << (FRAC_BITS + DATA_W - 1);
    localparam logic [DATA_W-1:0]       Z_MAX      = {1'b0, {(DATA_W-1){1'b1}}};
`endif

    state_t                     state;
    state_t                     state_next;
    logic                       accept;
    logic                       layer_done;
    logic                       final_layer;
    logic signed [DATA_W-1:0]   a_sel;
    logic signed [DATA_W-1:0]   b_sel;
    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    pre;
    logic [LAYER_W-1:0]         layer;
    logic [LAYER_W-1:0]         pre_layer;
    logic                       pre_valid;
    logic                       pre_final;
    logic [DATA_W-1:0]          z_next;

    // Loop muxes keep out-of-range sel codes (non power-of-two N_SEL) at a defined zero.
    always_comb begin
        a_sel = '0;
        for (int i = 0; i < N_SEL; i++) begin
            if (sel == SEL_W'(i)) begin
                a_sel = a_elements[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        b_sel = '0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (layer == LAYER_W'(i)) begin
                b_sel = b_elements[i*DATA_W +: DATA_W];
            end
        end
    end

    assign product     = (2*DATA_W)'(a_sel) * (2*DATA_W)'(b_sel);
    assign sum         = acc + ACC_W'(product);
    assign final_layer = (layer == LAST_LAYER);
    assign layer_done  = accept && last_element;
    assign busy        = (state != IDLE);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (go) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                // abort outranks a same-cycle accept: nothing is summed or emitted.
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    accept = a_element_ready && b_element_ready;
                    if (accept && last_element && final_layer) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            acc       <= '0;
            layer     <= '0;
            pre       <= '0;
            pre_layer <= '0;
            pre_valid <= 1'b0;
            pre_final <= 1'b0;
        end else begin
            pre_valid <= layer_done;
            pre_final <= layer_done && final_layer;
            if (state == IDLE && go) begin
                acc   <= '0;
                layer <= '0;
            end else if (state == RUN && abort) begin
                acc <= '0;
            end else if (accept) begin
                if (last_element) begin
                    pre       <= sum;
                    pre_layer <= layer;
                    acc       <= '0;
                    layer     <= final_layer ? '0 : layer + LAYER_W'(1);
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    always_comb begin
        z_next = pre[FRAC_BITS +: DATA_W];
        if (pre < ACC_ZERO) begin
            z_next = '0;
        end
`ifdef LAYERED_MAC_STAGE_SATURATE_EN
        else if (pre >= SAT_LIMIT) begin
            z_next = Z_MAX;
        end
`endif
    end

    // z_element and z_layer hold their value between results; only the strobes pulse.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            z_element       <= '0;
            z_element_ready <= 1'b0;
            z_layer         <= '0;
            done            <= 1'b0;
        end else begin
            z_element_ready <= pre_valid;
            done            <= pre_final;
            if (pre_valid) begin
                z_element <= z_next;
                z_layer   <= pre_layer;
            end
        end
    end

endmodule

// File: tb/tb_layered_mac_stage.sv
// Scoreboard bench for layered_mac_stage: drivers push model results, a negedge monitor pops and compares.
// Honours LAYERED_MAC_STAGE_SATURATE_EN in its reference model to match the build under test.
`timescale 1ns/1ps
module tb_layered_mac_stage;

    localparam int DATA_W    = 16;
    localparam int ACC_W     = 40;
    localparam int FRAC_BITS = 16;
    localparam int N_LAYERS  = 4;
    localparam int N_SEL     = 4;
    localparam int SEL_W     = 2;
    localparam int LAYER_W   = 2;

    logic                       clock = 1'b0;
    logic                       clear_n = 1'b0;
    logic                       go = 1'b0;
    logic                       abort = 1'b0;
    logic [SEL_W-1:0]           sel = '0;
    logic [N_SEL*DATA_W-1:0]    a_elements = '0;
    logic                       a_element_ready = 1'b0;
    logic [N_LAYERS*DATA_W-1:0] b_elements = '0;
    logic                       b_element_ready = 1'b0;
    logic                       last_element = 1'b0;
    logic [DATA_W-1:0]          z_element;
    logic                       z_element_ready;
    logic [LAYER_W-1:0]         z_layer;
    logic                       busy;
    logic                       done;

    typedef struct {
        logic [DATA_W-1:0] z;
        int                layer;
        bit                last_layer;
        int                cyc;
    } exp_t;

    exp_t   exp_q[$];
    int     compared = 0;
    int     mismatched = 0;
    int     cyc = 0;
    longint model_sum = 0;

    layered_mac_stage #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS),
        .N_LAYERS(N_LAYERS), .N_SEL(N_SEL)
    ) dut (
        .clock(clock), .clear_n(clear_n), .go(go), .abort(abort), .sel(sel),
        .a_elements(a_elements), .a_element_ready(a_element_ready),
        .b_elements(b_elements), .b_element_ready(b_element_ready),
        .last_element(last_element), .z_element(z_element),
        .z_element_ready(z_element_ready), .z_layer(z_layer),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: integer dot product wrapped to ACC_W, zero if negative, else floor-divide by 2^FRAC_BITS.
    function automatic logic [DATA_W-1:0] model_z(input longint s);
        longint m;
        longint v;
        m = longint'(1) << ACC_W;
        v = s & (m - 1);
        if (v >= m / 2) v = v - m;
        if (v < 0) return '0;
        v = v / (longint'(1) << FRAC_BITS);
`ifdef LAYERED_MAC_STAGE_SATURATE_EN
        if (v > (longint'(1) << (DATA_W - 1)) - 1) return DATA_W'((longint'(1) << (DATA_W - 1)) - 1);
`endif
        return DATA_W'(v);
    endfunction

    task automatic drive_bus(input int sel_i);
        sel = (sel_i < 0) ? SEL_W'($urandom_range(N_SEL - 1, 0)) : SEL_W'(sel_i);
        for (int i = 0; i < N_SEL; i++) a_elements[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        for (int i = 0; i < N_LAYERS; i++) b_elements[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    endtask

    // Random idle gaps (partial ready, stray last_element and go), then one accepted element.
    task automatic send(input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv, input int lyr,
                        input bit last, input int gap_max, input int sel_i);
        int gap;
        int pat;
        gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        for (int g = 0; g < gap; g++) begin
            drive_bus(sel_i);
            pat = int'($urandom_range(2, 0));
            a_element_ready = (pat == 1);
            b_element_ready = (pat == 2);
            last_element    = 1'($urandom);
            go              = 1'($urandom);
            @(posedge clock); #1;
        end
        drive_bus(sel_i);
        a_elements[sel*DATA_W +: DATA_W] = av;
        b_elements[lyr*DATA_W +: DATA_W] = bv;
        a_element_ready = 1'b1;
        b_element_ready = 1'b1;
        last_element    = last;
        go              = 1'b0;
        @(posedge clock); #1;
        model_sum += longint'($signed(av)) * longint'($signed(bv));
        if (last) begin
            exp_q.push_back('{z: model_z(model_sum), layer: lyr,
                              last_layer: (lyr == N_LAYERS - 1), cyc: cyc + 1});
            model_sum = 0;
        end
        a_element_ready = 1'b0;
        b_element_ready = 1'b0;
        last_element    = 1'b0;
    endtask

    task automatic random_layer(input int lyr, input int gap_max);
        int n;
        n = int'($urandom_range(5, 1));
        for (int e = 0; e < n; e++) send(DATA_W'($urandom), DATA_W'($urandom), lyr, e == n - 1, gap_max, -1);
    endtask

    task automatic start_run();
        go = 1'b1;
        @(posedge clock); #1;
        go = 1'b0;
        check("busy_after_go", busy, 1);
    endtask

    // Called right after the final layer's last accept: one FLUSH cycle, then IDLE.
    task automatic finish_run(input bit poke_go, input bit poke_abort);
        check("busy_in_flush", busy, 1);
        go    = poke_go;
        abort = poke_abort;
        @(posedge clock); #1;
        go    = 1'b0;
        abort = 1'b0;
        check("busy_fall", busy, 0);
        repeat (3) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (z_element_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", z_element_ready, 0);
            end else begin
                e = exp_q.pop_front();
                check("z_element", z_element, e.z);
                check("z_layer", z_layer, e.layer);
                check("done", done, e.last_layer);
                check("strobe_cycle", cyc, e.cyc);
            end
        end else if (done) begin
            check("done_without_strobe", done, 0);
        end
    end

    initial begin
        #1;
        check("rst_z_element", z_element, 0);
        check("rst_z_ready", z_element_ready, 0);
        check("rst_z_layer", z_layer, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(posedge clock);
        #1;
        clear_n = 1'b1;
        @(posedge clock); #1;

        // Basic dot product on sel=2: 3 x 0x0100*0x0200 -> 6.
        start_run();
        for (int e = 0; e < 3; e++) send(16'h0100, 16'h0200, 0, e == 2, 0, 2);
        for (int l = 1; l < N_LAYERS; l++) random_layer(l, 0);
        finish_run(1'b0, 1'b0);

        // Back-to-back layers, z = 2,4,6,8; go/abort during FLUSH are ignored.
        start_run();
        for (int l = 0; l < N_LAYERS; l++)
            for (int e = 0; e < 2; e++) send(16'h0100, DATA_W'((l + 1) * 256), l, e == 1, 0, -1);
        finish_run(1'b1, 1'b1);

        // Rectify a negative single-element vector.
        start_run();
        send(16'hFF00, 16'h0100, 0, 1'b1, 1, -1);
        for (int l = 1; l < N_LAYERS; l++) random_layer(l, 1);
        finish_run(1'b0, 1'b0);

        // Large positive sum: clamp or truncate depending on the build.
        start_run();
        for (int e = 0; e < 4; e++) send(16'h7FFF, 16'h7FFF, 0, e == 3, 0, -1);
        for (int l = 1; l < N_LAYERS; l++) random_layer(l, 0);
        finish_run(1'b0, 1'b0);

        // Random runs with stalls.
        for (int r = 0; r < 5; r++) begin
            start_run();
            for (int l = 0; l < N_LAYERS; l++) random_layer(l, 3);
            finish_run(1'b0, 1'b0);
        end

        // Abort mid-vector, coincident with an accept carrying last_element.
        start_run();
        send(DATA_W'($urandom), DATA_W'($urandom), 0, 1'b0, 1, -1);
        send(DATA_W'($urandom), DATA_W'($urandom), 0, 1'b0, 1, -1);
        drive_bus(-1);
        a_element_ready = 1'b1;
        b_element_ready = 1'b1;
        last_element    = 1'b1;
        abort           = 1'b1;
        @(posedge clock); #1;
        abort           = 1'b0;
        a_element_ready = 1'b0;
        b_element_ready = 1'b0;
        last_element    = 1'b0;
        model_sum       = 0;
        check("abort_idle", busy, 0);
        repeat (4) @(posedge clock);
        #1;
        start_run();
        send(16'h0100, 16'h0100, 0, 1'b1, 0, -1);
        for (int l = 1; l < N_LAYERS; l++) random_layer(l, 1);
        finish_run(1'b0, 1'b0);

        // Async reset between the last accept and its strobe.
        start_run();
        random_layer(0, 1);
        clear_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        model_sum = 0;
        check("areset_z_element", z_element, 0);
        check("areset_z_ready", z_element_ready, 0);
        check("areset_z_layer", z_layer, 0);
        check("areset_busy", busy, 0);
        check("areset_done", done, 0);
        repeat (2) @(posedge clock);
        #1;
        clear_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("post_reset_busy", busy, 0);

        // One more run after reset to confirm clean restart.
        start_run();
        for (int l = 0; l < N_LAYERS; l++) random_layer(l, 2);
        finish_run(1'b0, 1'b0);

        for (int w = 0; w < 20 && exp_q.size() != 0; w++) @(posedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
